// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// aes_round_sequencer : collects key/data blocks from a word stream, drives an
// external AES round core through rounds 0..NUM_ROUNDS, and streams the result.
// Revision: 1.0
// ============================================================================
module aes_round_sequencer #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_type,
  input  logic [WORD_W-1:0] in_word,
  input  logic              flush,
  output logic              round_start,
  output logic [3:0]        round_num,
  output logic              round_final,
  output logic [127:0]      round_state,
  input  logic [127:0]      round_result,
  input  logic              round_done,
  output logic              key_load,
  output logic [127:0]      key_out,
  output logic              key_loaded,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_last,
  output logic              busy,
  output logic              drop_err
);

  localparam int              WPB    = 128 / WORD_W;
  localparam int              CW     = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [CW-1:0]   LAST_W = CW'(WPB - 1);
  localparam logic [3:0]      LAST_R = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    KEYLOAD = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    SEND    = 3'd4
  } state_e;

  state_e          st_q, st_d;
  logic [127:0]    buf_q, buf_d;
  logic [127:0]    blk_q, blk_d;
  logic [127:0]    key_q, key_d;
  logic            key_loaded_q, key_loaded_d;
  logic [3:0]      r_q, r_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            type_q, type_d;
  logic            cur_type;

  logic in_ready_q, busy_q, round_start_q, round_final_q;
  logic key_load_q, out_valid_q, out_last_q, drop_err_q, drop_err_d;

  // Block type comes from the first word only; later in_type values are don't-care.
  assign cur_type = (wcnt_q == '0) ? in_type : type_q;

  always_comb begin
    st_d         = st_q;
    buf_d        = buf_q;
    blk_d        = blk_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    r_d          = r_q;
    wcnt_d       = wcnt_q;
    type_d       = type_q;
    drop_err_d   = 1'b0;
    if (flush) begin
      st_d   = COLLECT;
      wcnt_d = '0;
      r_d    = '0;
    end else begin
      case (st_q)
        COLLECT: begin
          if (in_valid && in_ready_q) begin
            buf_d  = {buf_q[127-WORD_W:0], in_word};
            type_d = cur_type;
            if (wcnt_q == LAST_W) begin
              wcnt_d = '0;
              if (cur_type) begin
                st_d         = KEYLOAD;
                key_d        = buf_d;
                key_loaded_d = 1'b1;
              end else if (key_loaded_q) begin
                st_d  = ISSUE;
                r_d   = '0;
                blk_d = buf_d;
              end else begin
                drop_err_d = 1'b1;
              end
            end else begin
              wcnt_d = wcnt_q + CW'(1);
            end
          end
        end
        KEYLOAD: st_d = COLLECT;
        ISSUE:   st_d = WAIT;
        WAIT: begin
          if (round_done) begin
            blk_d = round_result;
            if (r_q == LAST_R) begin
              st_d   = SEND;
              wcnt_d = '0;
            end else begin
              r_d  = r_q + 4'd1;
              st_d = ISSUE;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            blk_d = blk_q << WORD_W;
            if (wcnt_q == LAST_W) begin
              st_d   = COLLECT;
              wcnt_d = '0;
            end else begin
              wcnt_d = wcnt_q + CW'(1);
            end
          end
        end
        default: st_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st_q          <= COLLECT;
      buf_q         <= '0;
      blk_q         <= '0;
      key_q         <= '0;
      key_loaded_q  <= 1'b0;
      r_q           <= '0;
      wcnt_q        <= '0;
      type_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      round_start_q <= 1'b0;
      round_final_q <= 1'b0;
      key_load_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      st_q          <= st_d;
      buf_q         <= buf_d;
      blk_q         <= blk_d;
      key_q         <= key_d;
      key_loaded_q  <= key_loaded_d;
      r_q           <= r_d;
      wcnt_q        <= wcnt_d;
      type_q        <= type_d;
      in_ready_q    <= (st_d == COLLECT);
      busy_q        <= (st_d != COLLECT);
      round_start_q <= (st_d == ISSUE);
      round_final_q <= (st_d == ISSUE) && (r_d == LAST_R);
      key_load_q    <= (st_d == KEYLOAD);
      out_valid_q   <= (st_d == SEND);
      out_last_q    <= (st_d == SEND) && (wcnt_d == LAST_W);
      drop_err_q    <= drop_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign round_start = round_start_q;
  assign round_final = round_final_q;
  assign round_num   = r_q;
  assign round_state = blk_q;
  assign key_load    = key_load_q;
  assign key_out     = key_q;
  assign key_loaded  = key_loaded_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_word    = blk_q[127 -: WORD_W];
  assign drop_err    = drop_err_q;

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, bus word width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, AES round count; legal values 10, 12, 14.
REQ-003 SHALL provide: clk  in  1  sole clock, rising edge.
REQ-004 SHALL provide: n_rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL provide: in_valid in 1 word offered; in_ready out 1 word accepted when both high; in_type in 1 (0 data, 1 key); in_word in WORD_W.
REQ-006 SHALL provide: flush in 1 abort current block.
REQ-007 SHALL provide: round_start out 1; round_num out 4; round_final out 1; round_state out 128; round_result in 128; round_done in 1.
REQ-008 SHALL provide: key_load out 1; key_out out 128; key_loaded out 1.
REQ-009 SHALL provide: out_valid out 1; out_ready in 1; out_word out WORD_W; out_last out 1; busy out 1; drop_err out 1.

Function
REQ-010 SHALL define WPB = 128/WORD_W words per block.
REQ-011 SHALL use FSM states COLLECT, KEYLOAD, ISSUE, WAIT, SEND.
REQ-012 COLLECT: in_ready=1; each accepted word shifts in MSB-first, buf <= {buf[127-WORD_W:0], in_word}.
REQ-013 SHALL latch block type from the first word of a block and ignore in_type on later words.
REQ-014 On the WPB-th accepted word: key -> KEYLOAD; data with key_loaded=1 -> ISSUE, round counter r=0; data with key_loaded=0 -> one-cycle drop_err pulse, block discarded, stay COLLECT.
REQ-015 KEYLOAD: key_load=1 for exactly one cycle, key_out=buf, key_loaded set to 1, next state COLLECT.
REQ-016 ISSUE: round_start=1 for one cycle, round_num=r, round_state=state, round_final=(r==NUM_ROUNDS); next state WAIT.
REQ-017 WAIT: on round_done, state <= round_result; if r==NUM_ROUNDS -> SEND with word count 0, else r++ and -> ISSUE.
REQ-018 round_done SHALL be ignored in every state except WAIT.
REQ-019 Rounds issued SHALL be 0..NUM_ROUNDS inclusive (NUM_ROUNDS+1 transactions; round 0 = initial AddRoundKey).
REQ-020 SEND: out_valid=1, out_word=state[127:128-WORD_W]; on out_valid&&out_ready shift state left WORD_W; out_last=1 on word WPB-1; after last accepted word -> COLLECT.
REQ-021 out_word/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 With round_done returned the cycle after each round_start, out_valid SHALL rise 2*NUM_ROUNDS+3 cycles after the cycle the last input word is accepted.
REQ-023 busy SHALL be 1 in ISSUE, WAIT, SEND, KEYLOAD; in_ready=0 in those states.
REQ-024 flush=1 SHALL, next cycle, force COLLECT, clear word count, r, out_valid; key_loaded and key_out unchanged; flush overrides in_valid and round_done in the same cycle.
REQ-025 Partial blocks in COLLECT SHALL persist indefinitely until completed, flushed, or reset.

Reset
REQ-026 n_rst=0 at a rising edge SHALL set state COLLECT, buf, state register, key_out, r and word count to 0, and all 1-bit outputs (including key_loaded) to 0 except in_ready=1, regardless of current state.
REQ-027 Reset SHALL take priority over flush and all other inputs.

Verification
REQ-028 WORD_W=32, key words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c, in_type=1 -> one key_load pulse, key_out=0x2b7e151628aed2a6abf7158809cf4f3c, key_loaded=1.
REQ-029 Data block before any key -> single drop_err pulse after 4th word, no round_start, in_ready stays 1.
REQ-030 Key loaded, data 0x00112233..ccddeeff, stub core returns round_state+1 after 1 cycle -> 11 round_start pulses, round_num 0..10, round_final only on 10; output 0x00112233445566778899aabbccddef0a; out_valid exactly 23 cycles after last input accept.
REQ-031 Same block, out_ready toggled 1,0,0,1,... -> 4 words in order, stable while stalled, out_last on 4th only.
REQ-032 flush during WAIT at r=5 -> COLLECT next cycle, late round_done ignored, key_loaded=1, next block completes normally.
REQ-033 n_rst low during SEND -> out_valid=0, key_loaded=0, in_ready=1 next cycle; a subsequent data block produces drop_err.
